// File: rtl/button_event_ctrl.sv
// Arbitrates debounced buttons (lowest index wins) and emits press and hold-to-repeat
// key events on a valid/ready handshake, locking out other buttons until all are released.
module button_event_ctrl #(
    parameter int N_BTN         = 4,
    parameter int HOLD_CYCLES   = 8,
    parameter int REPEAT_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BTN-1:0]         btn_db,
    input  logic                     evt_ready,
    output logic                     evt_valid,
    output logic [$clog2(N_BTN)-1:0] evt_idx,
    output logic                     evt_repeat,
    output logic                     busy
);

    localparam int IDX_W   = $clog2(N_BTN);
    localparam int MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD    = 2'd1,
        REPEAT  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               evt_valid_q, evt_valid_d;
    logic [IDX_W-1:0]   evt_idx_q, evt_idx_d;
    logic               evt_repeat_q, evt_repeat_d;

    logic               any_btn;
    logic               owner_held;
    logic [IDX_W-1:0]   lowest_idx;
    logic               gen_evt;
    logic               gen_repeat;
    logic [IDX_W-1:0]   gen_idx;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_BTN-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = IDX_W'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    assign any_btn    = |btn_db;
    assign owner_held = btn_db[owner_q];
    assign lowest_idx = lowest_set(btn_db);

    assign evt_valid  = evt_valid_q;
    assign evt_idx    = evt_idx_q;
    assign evt_repeat = evt_repeat_q;
    assign busy       = (state_q != IDLE);

    // State, counter, owner and event payload registers; reset parks in RELEASE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RELEASE;
            cnt_q        <= '0;
            owner_q      <= '0;
            evt_valid_q  <= 1'b0;
            evt_idx_q    <= '0;
            evt_repeat_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            evt_valid_q  <= evt_valid_d;
            evt_idx_q    <= evt_idx_d;
            evt_repeat_q <= evt_repeat_d;
        end
    end

    // Next-state logic; owner release takes priority over counter expiry
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_btn) state_d = HELD;
                else         state_d = IDLE;
            end
            HELD: begin
                if (!owner_held)            state_d = RELEASE;
                else if (cnt_q == HOLD_LAST) state_d = REPEAT;
                else                         state_d = HELD;
            end
            REPEAT: begin
                if (!owner_held) state_d = RELEASE;
                else             state_d = REPEAT;
            end
            RELEASE: begin
                if (any_btn) state_d = RELEASE;
                else         state_d = IDLE;
            end
            default: state_d = RELEASE;
        endcase
    end

    // Counter, owner capture, event generation and single-slot handshake
    always_comb begin
        cnt_d      = '0;
        owner_d    = owner_q;
        gen_evt    = 1'b0;
        gen_repeat = 1'b0;
        gen_idx    = owner_q;
        case (state_q)
            IDLE: begin
                owner_d = lowest_idx;
                gen_idx = lowest_idx;
                gen_evt = any_btn;
            end
            HELD: begin
                if (owner_held && (cnt_q == HOLD_LAST)) begin
                    gen_evt    = 1'b1;
                    gen_repeat = 1'b1;
                end else if (owner_held) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            REPEAT: begin
                if (owner_held && (cnt_q == REPEAT_LAST)) begin
                    gen_evt    = 1'b1;
                    gen_repeat = 1'b1;
                end else if (owner_held) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            RELEASE: cnt_d = '0;
            default: cnt_d = '0;
        endcase

        // A new event only lands when the slot is free or draining this cycle; otherwise it is dropped
        if (gen_evt && (!evt_valid_q || evt_ready)) begin
            evt_valid_d  = 1'b1;
            evt_idx_d    = gen_idx;
            evt_repeat_d = gen_repeat;
        end else if (evt_valid_q && evt_ready) begin
            evt_valid_d  = 1'b0;
            evt_idx_d    = evt_idx_q;
            evt_repeat_d = evt_repeat_q;
        end else begin
            evt_valid_d  = evt_valid_q;
            evt_idx_d    = evt_idx_q;
            evt_repeat_d = evt_repeat_q;
        end
    end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench for button_event_ctrl: expected transfers (idx, repeat, edge number)
// are queued as stimulus is applied and matched when the handshake completes.
module tb_button_event_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] btn_db;
    logic       evt_ready;
    logic       evt_valid;
    logic [1:0] evt_idx;
    logic       evt_repeat;
    logic       busy;

    typedef struct {
        logic [1:0] idx;
        logic       rep;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_fail;

    logic       prev_v;
    logic       prev_r;
    logic       prev_rst;
    logic [1:0] prev_idx;
    logic       prev_rep;

    button_event_ctrl #(
        .N_BTN(4),
        .HOLD_CYCLES(8),
        .REPEAT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_db(btn_db),
        .evt_ready(evt_ready),
        .evt_valid(evt_valid),
        .evt_idx(evt_idx),
        .evt_repeat(evt_repeat),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic [1:0] idx, input logic rep, input int at_edge);
        exp_t e;
        e.idx = idx;
        e.rep = rep;
        e.cyc = at_edge;
        sb.push_back(e);
    endtask

    // Runs at the falling edge: payload stability and transfer scoreboarding
    task automatic monitor();
        exp_t e;
        if (!rst && !prev_rst && prev_v && !prev_r) begin
            n_checks++;
            if (evt_valid !== 1'b1 || evt_idx !== prev_idx || evt_repeat !== prev_rep) begin
                n_fail++;
                $display("FAIL hold_stable @%0d: got v=%b idx=%0d rep=%b, need v=1 idx=%0d rep=%b",
                         cyc, evt_valid, evt_idx, evt_repeat, prev_idx, prev_rep);
            end
        end
        if (!rst && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event @%0d: got idx=%0d rep=%b, need no event",
                         cyc + 1, evt_idx, evt_repeat);
            end else begin
                e = sb.pop_front();
                if (evt_idx !== e.idx) begin
                    n_fail++;
                    $display("FAIL evt_idx @%0d: got %0d need %0d", cyc + 1, evt_idx, e.idx);
                end
                n_checks++;
                if (evt_repeat !== e.rep) begin
                    n_fail++;
                    $display("FAIL evt_repeat @%0d: got %b need %b", cyc + 1, evt_repeat, e.rep);
                end
                n_checks++;
                if (cyc + 1 != e.cyc) begin
                    n_fail++;
                    $display("FAIL evt_timing: got edge %0d need edge %0d", cyc + 1, e.cyc);
                end
            end
        end
        prev_v   = evt_valid;
        prev_r   = evt_ready;
        prev_rst = rst;
        prev_idx = evt_idx;
        prev_rep = evt_repeat;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained: got %0d pending expected events, need 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_busy(input string name, input logic exp_busy);
        n_checks++;
        if (busy !== exp_busy) begin
            n_fail++;
            $display("FAIL %s_busy: got %b need %b", name, busy, exp_busy);
        end
    endtask

    task automatic check_valid(input string name, input logic exp_v);
        n_checks++;
        if (evt_valid !== exp_v) begin
            n_fail++;
            $display("FAIL %s_valid: got %b need %b", name, evt_valid, exp_v);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_db = 4'b0100;
        evt_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_valid("reset", 1'b0);
        n_checks++;
        if (evt_idx !== 2'd0 || evt_repeat !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_payload: got idx=%0d rep=%b need idx=0 rep=0", evt_idx, evt_repeat);
        end
        check_busy("reset", 1'b1);
        repeat (5) tick();
        check_busy("held_thru_reset", 1'b1);
        btn_db = 4'b0000;
        tick();
        check_busy("reset_to_idle", 1'b0);
        check_drained("reset");
    endtask

    task automatic test_single_tap();
        int t;
        t = cyc + 1;
        btn_db = 4'b0010;
        push_exp(2'd1, 1'b0, t + 1);
        repeat (3) tick();
        btn_db = 4'b0000;
        check_valid("tap_once", 1'b0);
        tick();
        check_busy("tap_release", 1'b1);
        tick();
        check_busy("tap_idle", 1'b0);
        check_drained("tap");
    endtask

    task automatic test_simultaneous();
        int t;
        t = cyc + 1;
        btn_db = 4'b1010;
        push_exp(2'd1, 1'b0, t + 1);
        tick();
        btn_db = 4'b1000;
        repeat (10) tick();
        check_busy("lockout", 1'b1);
        btn_db = 4'b0000;
        repeat (2) tick();
        t = cyc + 1;
        btn_db = 4'b1000;
        push_exp(2'd3, 1'b0, t + 1);
        tick();
        btn_db = 4'b0000;
        repeat (3) tick();
        check_drained("simultaneous");
    endtask

    task automatic test_hold_repeat();
        int t;
        t = cyc + 1;
        btn_db = 4'b0001;
        push_exp(2'd0, 1'b0, t + 1);
        push_exp(2'd0, 1'b1, t + 9);
        push_exp(2'd0, 1'b1, t + 13);
        push_exp(2'd0, 1'b1, t + 17);
        repeat (20) tick();
        btn_db = 4'b0000;
        repeat (6) tick();
        check_busy("repeat_idle", 1'b0);
        check_drained("hold_repeat");
    endtask

    task automatic test_backpressure();
        int t;
        t = cyc + 1;
        evt_ready = 1'b0;
        btn_db = 4'b0001;
        push_exp(2'd0, 1'b0, t + 11);
        push_exp(2'd0, 1'b1, t + 13);
        push_exp(2'd0, 1'b1, t + 17);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 10) evt_ready = 1'b1;
        end
        btn_db = 4'b0000;
        repeat (6) tick();
        check_drained("backpressure");
    endtask

    task automatic test_reset_mid();
        int t;
        evt_ready = 1'b0;
        btn_db = 4'b0100;
        repeat (10) tick();
        check_valid("pre_reset_pending", 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_valid("mid_reset", 1'b0);
        check_busy("mid_reset", 1'b1);
        evt_ready = 1'b1;
        repeat (10) tick();
        check_busy("mid_reset_locked", 1'b1);
        btn_db = 4'b0000;
        repeat (2) tick();
        check_busy("mid_reset_idle", 1'b0);
        t = cyc + 1;
        btn_db = 4'b0100;
        push_exp(2'd2, 1'b0, t + 1);
        tick();
        btn_db = 4'b0000;
        repeat (3) tick();
        check_drained("reset_mid");
    endtask

    task automatic test_release_race();
        int t;
        t = cyc + 1;
        btn_db = 4'b0001;
        push_exp(2'd0, 1'b0, t + 1);
        repeat (8) tick();
        btn_db = 4'b0000;
        tick();
        check_busy("race_release", 1'b1);
        check_valid("race_no_repeat", 1'b0);
        tick();
        check_busy("race_idle", 1'b0);
        repeat (3) tick();
        check_drained("race");
    endtask

    initial begin
        cyc = 0;
        n_checks = 0;
        n_fail = 0;
        prev_v = 1'b0;
        prev_r = 1'b0;
        prev_rst = 1'b1;
        prev_idx = 2'd0;
        prev_rep = 1'b0;
        rst = 1'b1;
        btn_db = 4'b0000;
        evt_ready = 1'b1;
        test_reset();
        test_single_tap();
        test_simultaneous();
        test_hold_repeat();
        test_backpressure();
        test_reset_mid();
        test_release_race();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
